// File: rtl/main_circuit_if.sv
// Operand/result bundle for main_circuit: qualified A..D in,
// registered terms, functions and event counters out.
interface main_circuit_if #(
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               A;
    logic               B;
    logic               C;
    logic               D;
    logic               out_valid;
    logic               F1;
    logic               F2;
    logic [3:0]         T;
    logic [COUNT_W-1:0] f1_count;
    logic [COUNT_W-1:0] f2_count;

    modport master (
        output in_valid, A, B, C, D,
        input  out_valid, F1, F2, T, f1_count, f2_count
    );

    modport slave (
        input  in_valid, A, B, C, D,
        output out_valid, F1, F2, T, f1_count, f2_count
    );
endinterface

// File: rtl/main_circuit.sv
// Four-term logic core with registered F1/F2/T outputs and
// saturating counters of valid samples that assert F1/F2.
module main_circuit #(
    parameter int COUNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    main_circuit_if.slave bus
);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic [3:0]         t_now;
    logic               f1_now;
    logic               f2_now;

    logic [3:0]         t_d, t_q;
    logic               f1_d, f1_q;
    logic               f2_d, f2_q;
    logic               vld_d, vld_q;
    logic [COUNT_W-1:0] c1_d, c1_q;
    logic [COUNT_W-1:0] c2_d, c2_q;

    always_comb begin
        t_now[0] = bus.A & bus.B;
        t_now[1] = ~bus.A & bus.B;
        t_now[2] = bus.C ^ bus.D;
        t_now[3] = ~(bus.C | bus.D);
        f1_now   = t_now[0] | t_now[2];
        f2_now   = t_now[1] & t_now[3];
    end

    // Results only move on a valid sample; A..D are ignored otherwise.
    always_comb begin
        t_d   = t_q;
        f1_d  = f1_q;
        f2_d  = f2_q;
        c1_d  = c1_q;
        c2_d  = c2_q;
        vld_d = bus.in_valid;
        if (bus.in_valid) begin
            t_d  = t_now;
            f1_d = f1_now;
            f2_d = f2_now;
            if (f1_now && (c1_q != CNT_MAX)) begin
                c1_d = c1_q + CNT_ONE;
            end
            if (f2_now && (c2_q != CNT_MAX)) begin
                c2_d = c2_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q   <= '0;
            f1_q  <= 1'b0;
            f2_q  <= 1'b0;
            vld_q <= 1'b0;
            c1_q  <= '0;
            c2_q  <= '0;
        end else begin
            t_q   <= t_d;
            f1_q  <= f1_d;
            f2_q  <= f2_d;
            vld_q <= vld_d;
            c1_q  <= c1_d;
            c2_q  <= c2_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.F1        = f1_q;
    assign bus.F2        = f2_q;
    assign bus.T         = t_q;
    assign bus.f1_count  = c1_q;
    assign bus.f2_count  = c2_q;
endmodule

// File: tb/tb_main_circuit.sv
// Bench for main_circuit: two instances (16-bit and 2-bit counters)
// share one stimulus stream and are checked against a sample-level model.
module tb_main_circuit;
    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic A, B, C, D;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    main_circuit_if #(.COUNT_W(16)) bus16 ();
    main_circuit_if #(.COUNT_W(2))  bus2 ();

    assign bus16.in_valid = in_valid;
    assign bus16.A = A;
    assign bus16.B = B;
    assign bus16.C = C;
    assign bus16.D = D;
    assign bus2.in_valid = in_valid;
    assign bus2.A = A;
    assign bus2.B = B;
    assign bus2.C = C;
    assign bus2.D = D;

    main_circuit #(.COUNT_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    main_circuit #(.COUNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Model: what the registered outputs must hold after each edge.
    bit       m_v;
    bit       m_f1;
    bit       m_f2;
    bit [3:0] m_t;
    int       m_c1;
    int       m_c2;
    int       m_s1;
    int       m_s2;

    task automatic model(input bit r, input bit v, input bit [3:0] abcd);
        bit a, b, c, d, t1, t2, t3, t4;
        if (r) begin
            m_v = 0; m_f1 = 0; m_f2 = 0; m_t = 0;
            m_c1 = 0; m_c2 = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            m_v = v;
            if (v) begin
                {a, b, c, d} = abcd;
                t1 = a && b;
                t2 = !a && b;
                t3 = (c != d);
                t4 = !c && !d;
                m_f1 = t1 || t3;
                m_f2 = t2 && t4;
                m_t  = {t4, t3, t2, t1};
                if (m_f1) begin
                    if (m_c1 < 65535) m_c1++;
                    if (m_s1 < 3) m_s1++;
                end
                if (m_f2) begin
                    if (m_c2 < 65535) m_c2++;
                    if (m_s2 < 3) m_s2++;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ov16", 32'(bus16.out_valid), 32'(m_v));
            chk("f1_16", 32'(bus16.F1), 32'(m_f1));
            chk("f2_16", 32'(bus16.F2), 32'(m_f2));
            chk("t16", 32'(bus16.T), 32'(m_t));
            chk("c1_16", 32'(bus16.f1_count), m_c1);
            chk("c2_16", 32'(bus16.f2_count), m_c2);
            chk("ov2", 32'(bus2.out_valid), 32'(m_v));
            chk("t2", 32'(bus2.T), 32'(m_t));
            chk("c1_2", 32'(bus2.f1_count), m_s1);
            chk("c2_2", 32'(bus2.f2_count), m_s2);
        end
    end

    // Inputs change at the falling edge; results are read a half cycle
    // after the rising edge that captured them.
    task automatic step(input bit r, input bit v, input logic [3:0] abcd);
        rst = r;
        in_valid = v;
        {A, B, C, D} = abcd;
        @(posedge clk);
        model(r, v, abcd);
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    logic [3:0] tv_in  [5];
    logic [5:0] tv_out [5];
    int         sat_exp[6];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        {A, B, C, D} = 4'b0000;
        tv_in  = '{4'b0000, 4'b1100, 4'b0010, 4'b0100, 4'b1111};
        tv_out = '{6'b00_1000, 6'b10_1001, 6'b10_0100,
                   6'b01_1010, 6'b10_0001};
        sat_exp = '{1, 2, 3, 3, 3, 3};
        @(negedge clk);

        step(1, 1, 4'b1111);
        step(1, 1, 4'b1111);
        chk("rst_f1", 32'(bus16.F1), 0);
        chk("rst_f2", 32'(bus16.F2), 0);
        chk("rst_t", 32'(bus16.T), 0);
        chk("rst_ov", 32'(bus16.out_valid), 0);
        chk("rst_c1", 32'(bus16.f1_count), 0);
        chk("rst_c2", 32'(bus16.f2_count), 0);

        for (int i = 0; i < 5; i++) begin
            step(0, 1, tv_in[i]);
            chk($sformatf("tv%0d", i),
                32'({bus16.F1, bus16.F2, bus16.T}), 32'(tv_out[i]));
            chk($sformatf("tv%0d_ov", i), 32'(bus16.out_valid), 1);
        end

        step(1, 0, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 4'(i));
            chk($sformatf("sweep%0d_ov", i), 32'(bus16.out_valid), 1);
        end
        chk("sweep_c1", 32'(bus16.f1_count), 10);
        chk("sweep_c2", 32'(bus16.f2_count), 1);
        chk("sweep_c1_sat", 32'(bus2.f1_count), 3);

        step(0, 1, 4'b0100);
        step(0, 0, 4'bxxxx);
        chk("hold_f2", 32'(bus16.F2), 1);
        chk("hold_f1", 32'(bus16.F1), 0);
        chk("hold_ov", 32'(bus16.out_valid), 0);
        chk("hold_c2", 32'(bus16.f2_count), 2);
        chk("hold_c1", 32'(bus16.f1_count), 10);

        step(1, 0, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 4'b1100);
            chk($sformatf("sat%0d_c1", i), 32'(bus2.f1_count), sat_exp[i]);
            chk($sformatf("sat%0d_c2", i), 32'(bus2.f2_count), 0);
        end

        step(1, 1, 4'b0100);
        chk("mid_f2", 32'(bus16.F2), 0);
        chk("mid_c2", 32'(bus16.f2_count), 0);
        chk("mid_ov", 32'(bus16.out_valid), 0);
        step(0, 1, 4'b0100);
        chk("resume_f2", 32'(bus16.F2), 1);
        chk("resume_c2", 32'(bus16.f2_count), 1);

        for (int i = 0; i < 400; i++) begin
            bit r, v;
            logic [3:0] abcd;
            r = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            abcd = 4'($urandom_range(0, 15));
            if (!v && !r && $urandom_range(0, 3) == 0) abcd = 4'bxxxx;
            step(r, v, abcd);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
